// File: rtl/alu_exec_stage.sv
// Registered 64-bit execute stage: add/sub/and/xor, signed overflow and a valid/ready output register.
// Optional {ZF,SF,OF} condition-code register and condition evaluation under `ALU_EXEC_CC_EN.
module alu_exec_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fun,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  input  logic [2:0]       in_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic             out_of,
  output logic             out_cnd,
  output logic [2:0]       cc_out
);

  localparam int MSB = WIDTH - 1;

  logic             accept_s;
  logic [WIDTH-1:0] res_s;
  logic             of_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_val_r;
  logic             out_of_r;

  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_val   = out_val_r;
  assign out_of    = out_of_r;

  // Function unit: wrapping result plus signed-overflow detection from operand/result sign bits.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    of_s  = 1'b0;
    case (in_fun)
      2'd0: begin
        res_s = in_a + in_b;
        of_s  = (in_a[MSB] == in_b[MSB]) && (res_s[MSB] != in_a[MSB]);
      end
      2'd1: begin
        res_s = in_a - in_b;
        of_s  = (in_a[MSB] != in_b[MSB]) && (res_s[MSB] != in_a[MSB]);
      end
      2'd2: begin
        res_s = in_a & in_b;
        of_s  = 1'b0;
      end
      2'd3: begin
        res_s = in_a ^ in_b;
        of_s  = 1'b0;
      end
      default: begin
        res_s = {WIDTH{1'b0}};
        of_s  = 1'b0;
      end
    endcase
  end

  // One-deep result register; a drain without a new accept keeps the data but drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_val_r   <= {WIDTH{1'b0}};
      out_of_r    <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_val_r   <= res_s;
      out_of_r    <= of_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef ALU_EXEC_CC_EN
  logic [2:0] cc_r;
  logic       out_cnd_r;
  logic [2:0] flags_s;
  logic       cnd_s;

  // cc layout is {ZF,SF,OF}; "less than" is SF^OF.
  function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] cond);
    logic lt;
    lt = cc[1] ^ cc[0];
    case (cond)
      3'd0:    cond_eval = 1'b1;
      3'd1:    cond_eval = lt | cc[2];
      3'd2:    cond_eval = lt;
      3'd3:    cond_eval = cc[2];
      3'd4:    cond_eval = !cc[2];
      3'd5:    cond_eval = !lt;
      3'd6:    cond_eval = !lt && !cc[2];
      3'd7:    cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Condition uses the CC value before this op's own flags land.
  always_comb begin
    flags_s = {(res_s == {WIDTH{1'b0}}), res_s[MSB], of_s};
    cnd_s   = cond_eval(cc_r, in_cond);
  end

  // Condition-code register and registered condition outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_r      <= 3'b100;
      out_cnd_r <= 1'b0;
    end else if (accept_s) begin
      out_cnd_r <= cnd_s;
      if (in_set_cc) begin
        cc_r <= flags_s;
      end
    end
  end

  assign cc_out  = cc_r;
  assign out_cnd = out_cnd_r;
`else
  logic unused_cc_s;

  assign unused_cc_s = ^{in_set_cc, in_cond};
  assign cc_out      = 3'b000;
  assign out_cnd     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized traffic
// against a cycle-level arithmetic reference model of the stage.
module tb_alu_exec_stage;

`ifdef ALU_EXEC_CC_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fun;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_set_cc;
  logic [2:0]  in_cond;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_val;
  logic        out_of;
  logic        out_cnd;
  logic [2:0]  cc_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid;
  logic [63:0] m_val;
  bit          m_of;
  bit          m_cnd;
  logic [2:0]  m_cc;

  alu_exec_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fun(in_fun), .in_a(in_a), .in_b(in_b),
    .in_set_cc(in_set_cc), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_val(out_val), .out_of(out_of), .out_cnd(out_cnd),
    .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  // Signed overflow = true mathematical result does not fit in 64 bits.
  function automatic void model_op(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] r, output bit of);
    logic signed [65:0] wide;
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    wide = 66'sd0;
    of = 1'b0;
    case (f)
      2'd0: wide = sa + sb;
      2'd1: wide = sa - sb;
      default: wide = 66'sd0;
    endcase
    if (f == 2'd2) r = a & b;
    else if (f == 2'd3) r = a ^ b;
    else begin
      r  = wide[63:0];
      of = (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -66'sh0_8000_0000_0000_0000);
    end
  endfunction

  function automatic bit cond_true(input logic [2:0] cc, input logic [2:0] cond);
    bit zf, lt;
    zf = cc[2];
    lt = cc[1] ^ cc[0];
    case (cond)
      3'd0: return 1'b1;
      3'd1: return lt || zf;
      3'd2: return lt;
      3'd3: return zf;
      3'd4: return !zf;
      3'd5: return !lt;
      3'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_cc();
    return CC_EN ? m_cc : 3'b000;
  endfunction

  task automatic drive(input bit v, input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                       input bit sc, input logic [2:0] cd, input bit ordy);
    in_valid = v; in_fun = f; in_a = a; in_b = b;
    in_set_cc = sc; in_cond = cd; out_ready = ordy;
  endtask

  // Advance model from the inputs presented this cycle, then clock and settle.
  task automatic tick();
    logic [63:0] r;
    bit of;
    if (rst) begin
      m_valid = 1'b0; m_val = 64'd0; m_of = 1'b0; m_cnd = 1'b0; m_cc = 3'b100;
    end else if (in_valid && (!m_valid || out_ready)) begin
      model_op(in_fun, in_a, in_b, r, of);
      m_cnd = CC_EN ? cond_true(m_cc, in_cond) : 1'b0;
      if (in_set_cc) m_cc = {(r == 64'd0), r[63], of};
      m_val = r; m_of = of; m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'd0, 64'd5, 64'd7, 1'b1, 3'd0, 1'b1);
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_val !== 64'd0) begin n_fail++; $display("FAIL reset_val: got %h want 0", out_val); end
    n_checks++; if (cc_out !== (CC_EN ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL reset_cc: got %b want %b", cc_out, exp_cc()); end
    n_checks++; if ({out_of, out_cnd} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {out_of, out_cnd}); end
    rst = 1'b0;
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 3'd0, 1'b1);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_sub_setcc();
    logic [63:0] expv;
    expv = 64'd0 - 64'd11111111111;
    drive(1'b1, 2'd1, 64'd22222222222, 64'd33333333333, 1'b1, 3'd0, 1'b1);
    tick();
    n_checks++; if (out_val !== expv || out_of !== 1'b0) begin n_fail++; $display("FAIL sub_val: got %h/%b want %h/0", out_val, out_of, expv); end
    n_checks++; if (cc_out !== (CC_EN ? 3'b010 : 3'b000)) begin n_fail++; $display("FAIL sub_cc: got %b want %b", cc_out, exp_cc()); end
    drive(1'b1, 2'd1, 64'd22222222222, 64'd22222222222, 1'b1, 3'd0, 1'b1);
    tick();
    n_checks++; if (out_val !== 64'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %h/%b want 0/1", out_val, out_valid); end
    n_checks++; if (cc_out !== (CC_EN ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL sub_zero_cc: got %b want %b", cc_out, exp_cc()); end
  endtask

  task automatic test_overflow();
    drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 3'd0, 1'b1);
    tick();
    n_checks++; if (out_val !== 64'h8000_0000_0000_0000 || out_of !== 1'b1) begin n_fail++; $display("FAIL add_ovf: got %h/%b want 8000000000000000/1", out_val, out_of); end
    drive(1'b1, 2'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 3'd0, 1'b1);
    tick();
    n_checks++; if (out_val !== 64'h7FFF_FFFF_FFFF_FFFF || out_of !== 1'b1) begin n_fail++; $display("FAIL sub_ovf: got %h/%b want 7fffffffffffffff/1", out_val, out_of); end
    drive(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 3'd0, 1'b1);
    tick();
    n_checks++; if (out_val !== 64'd0 || out_of !== 1'b0) begin n_fail++; $display("FAIL add_wrap: got %h/%b want 0/0", out_val, out_of); end
  endtask

  task automatic test_cond_order();
    drive(1'b1, 2'd1, 64'd1, 64'd2, 1'b1, 3'd7, 1'b1);
    tick();
    drive(1'b1, 2'd0, 64'd5, 64'd3, 1'b1, 3'd2, 1'b1);
    tick();
    n_checks++; if (out_cnd !== (CC_EN ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL cond_pre: got %b want %b", out_cnd, CC_EN); end
    n_checks++; if (cc_out !== (CC_EN ? 3'b000 : 3'b000) || out_val !== 64'd8) begin n_fail++; $display("FAIL cond_cc: got %b/%h want 000/8", cc_out, out_val); end
    drive(1'b1, 2'd2, 64'd6, 64'd3, 1'b0, 3'd2, 1'b1);
    tick();
    n_checks++; if (out_cnd !== 1'b0 || out_val !== 64'd2) begin n_fail++; $display("FAIL cond_post: got %b/%h want 0/2", out_cnd, out_val); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd0, 64'd100, 64'd23, 1'b0, 3'd0, 1'b1);
    tick();
    drive(1'b1, 2'd3, 64'hF0F0, 64'h0FF0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
      n_checks++; if (out_val !== 64'd123 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%b want 7b/1", i, out_val, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    n_checks++; if (out_val !== 64'hFF00 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next: got %h/%b want ff00/1", out_val, out_valid); end
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 3'd0, 1'b1);
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_val !== 64'hFF00) begin n_fail++; $display("FAIL bp_drain: got %b/%h want 0/ff00", out_valid, out_val); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 2'd1, 64'd1, 64'd2, 1'b1, 3'd0, 1'b1);
    tick();
    drive(1'b1, 2'd0, 64'd5, 64'd6, 1'b1, 3'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_val !== 64'd0) begin n_fail++; $display("FAIL rst_stall_out: got %b/%h want 0/0", out_valid, out_val); end
    n_checks++; if (cc_out !== (CC_EN ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL rst_stall_cc: got %b want %b", cc_out, exp_cc()); end
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    int mode;
    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = $urandom_range(0, 3);
      if (mode == 1) b = a;
      else if (mode == 2) begin
        a = ($urandom_range(0, 1) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
        b = 64'(signed'($urandom_range(0, 4)) - 2);
      end
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, b,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      #1;
      n_checks++; if (in_ready !== (!m_valid || out_ready)) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, !m_valid || out_ready); end
      tick();
      n_checks++;
      if (out_valid !== m_valid || out_val !== m_val || out_of !== m_of || out_cnd !== m_cnd || cc_out !== exp_cc()) begin
        n_fail++;
        $display("FAIL rnd_out[%0d]: got v=%b val=%h of=%b cnd=%b cc=%b want v=%b val=%h of=%b cnd=%b cc=%b",
                 i, out_valid, out_val, out_of, out_cnd, cc_out, m_valid, m_val, m_of, m_cnd, exp_cc());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 3'd0, 1'b1);
    m_valid = 1'b0; m_val = 64'd0; m_of = 1'b0; m_cnd = 1'b0; m_cc = 3'b100;
    test_reset();
    test_sub_setcc();
    test_overflow();
    test_cond_order();
    test_backpressure();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage of the 64-bit datapath that consumes decoded operands and produces the arithmetic result, the signed-overflow flag and the condition-code state. It wraps the add/subtract/logic function, including the signed subtract that yields `diff`/`overflow`, behind a valid/ready handshake with a one-deep output register. It also maintains the {ZF,SF,OF} condition-code register that feeds branch and conditional-move resolution downstream.

## Interface
- `WIDTH`, 64, operand/result width in bits, two's complement.
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `in_valid` input 1 — upstream operand bundle valid.
- `in_ready` output 1 — stage can accept a bundle this cycle.
- `in_fun` input 2 — 0 add (a+b), 1 sub (a−b), 2 and, 3 xor.
- `in_a` input WIDTH — operand A, signed.
- `in_b` input WIDTH — operand B, signed.
- `in_set_cc` input 1 — update CC register with this op's flags.
- `in_cond` input 3 — condition to evaluate for `out_cnd`.
- `out_valid` output 1 — result register holds a valid result.
- `out_ready` input 1 — downstream accepts result this cycle.
- `out_val` output WIDTH — registered result.
- `out_of` output 1 — registered signed-overflow flag of this op.
- `out_cnd` output 1 — registered condition outcome.
- `cc_out` output 3 — current CC register {ZF,SF,OF}.

## Operation
- Accept: `in_valid && in_ready`. `in_ready = !out_valid || out_ready` (combinational, no skid buffer).
- On accept: `out_val`, `out_of`, `out_cnd` loaded; `out_valid` set. On `out_valid && out_ready` with no accept: `out_valid` cleared, data held.
- Arithmetic: results wrap modulo 2^WIDTH.
  - add OF = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - sub OF = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - and/xor OF = 0.
- Flags of op: ZF = (r==0), SF = r[MSB], OF as above.
- CC register updated only on accept with `in_set_cc=1`; otherwise unchanged.
- `out_cnd` evaluated against CC value **before** this op's update, using `S = SF^OF`:
  - 0 always 1; 1 le `S|ZF`; 2 l `S`; 3 e `ZF`; 4 ne `!ZF`; 5 ge `!S`; 6 g `!S&&!ZF`; 7 never 0.
- Back-to-back accepts: op N+1 sees CC as updated by op N.
- Held result is not affected by CC changes.
- `rst` mid-operation: held result is discarded, with no partial transfer.

## Timing
- Latency 1 cycle from accept to `out_valid`. Throughput 1 per cycle while `out_ready=1`.
- Reset values: `out_valid=0`, `out_val=0`, `out_of=0`, `out_cnd=0`, CC = {ZF=1,SF=0,OF=0}. `in_ready=1` in the cycle after reset.
- `cc_out` is registered and changes the cycle after an accept with `in_set_cc`.
- `out_val`, `out_of` and `out_cnd` must stay stable while `out_valid && !out_ready`.
- Simultaneous drain and accept in one cycle: new result loaded, `out_valid` stays 1.
- `rst` overrides any accept in the same cycle.

## Configuration
- `ALU_EXEC_CC_EN` defined: CC register, `cc_out` and condition evaluation are present as above.
- Not defined:
  - No CC register.
  - `cc_out` tied 3'b000 and `out_cnd` tied 0.
  - `in_set_cc` and `in_cond` ignored.
  - Result, `out_of` and handshake behaviour identical.

## Test plan
- Reset: assert `rst` 2 cycles -> `out_valid=0`, `cc_out=3'b100`, `in_ready=1`.
- Sub with set_cc: a=22222222222, b=33333333333, fun=1 -> `out_val=-11111111111`, `out_of=0`; next cycle `cc_out=3'b010`. Then a=b=22222222222 -> `out_val=0`, `cc_out=3'b100`.
- Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> `out_val=0x8000_0000_0000_0000`, `out_of=1`. a=0x8000_0000_0000_0000, b=1, sub -> `out_val=0x7FFF_FFFF_FFFF_FFFF`, `out_of=1`.
- Condition ordering: CC=SF=1 from prior op, then an op with set_cc and cond=2 (l) producing a positive result -> `out_cnd=1`; following op with cond=2 -> `out_cnd=0`.
- Backpressure: `out_ready=0` for 3 cycles with `in_valid=1` -> `in_ready=0`, `out_val` stable. Release -> queued bundle accepted the same cycle, next result appears one cycle later, and no bundle is lost or duplicated.
- Reset mid-stall: `rst` while `out_valid=1` and `out_ready=0` -> `out_valid=0` and CC restored to 3'b100 next cycle.
